pu_or1k_pfpu_addsub_gen: RTL and testbench
==========================================

PU_OR1K_PFPU_ADDSUB_GEN -- requirements
Module: pu_or1k_pfpu_addsub_gen

Interface
REQ-001 SHALL have parameter FRACTW, default 24, meaning fraction width including hidden bit (24 = single, 53 = double).
REQ-002 SHALL have parameter EXPW, default 10, meaning width of the extended biased exponent.
REQ-003 SHALL have derived parameter SHW = clog2(FRACTW+3), meaning shift-amount width (5 at defaults).
REQ-004 SHALL have clk  input  1, meaning the single clock.
REQ-005 SHALL have rst  input  1, meaning reset; asynchronous, active-high.
REQ-006 SHALL have flush_i  input  1, meaning kill all in-flight operations.
REQ-007 SHALL have adv_i  input  1, meaning advance pipe; when 0 all stages hold.
REQ-008 SHALL have start_i  input  1, meaning operand-valid qualifier.
REQ-009 SHALL have is_sub_i  input  1, meaning 1 = subtract, 0 = add.
REQ-010 SHALL have signa_i/signb_i  input  1 each, exp_a_i/exp_b_i  input  EXPW each, fract_a_i/fract_b_i  input  FRACTW each, infa_i/infb_i  input  1 each.
REQ-011 SHALL have snan_i, qnan_i, anan_sign_i  input  1 each, meaning pre-decoded NaN info.
REQ-012 SHALL have add_rdy_o  output  1, meaning result valid.
REQ-013 SHALL have add_sign_o, add_sub_0_o, add_inv_o, add_inf_o, add_snan_o, add_qnan_o, add_anan_sign_o  output  1 each.
REQ-014 SHALL have add_shl_o  output  SHW, meaning left-normalise amount.
REQ-015 SHALL have add_exp_shl_o and add_exp_sh0_o  output  EXPW each, meaning exponent after left shift / with no shift.
REQ-016 SHALL have add_fract_o  output  FRACTW+4, meaning {carry, fraction, g, r, sticky}.
REQ-017 SHALL have busy_o  output  1, meaning some stage holds a valid operation.

Function
REQ-018 SHALL compute operand magnitude order internally: a_gt_b = {exp_a,fract_a} > {exp_b,fract_b}; a_eq_b on equality. No external compare inputs.
REQ-019 SHALL be a 3-stage pipeline: align-prep, shift+add, normalise-prep. Each stage register loads only when adv_i=1; latency is exactly 3 advancing cycles.
REQ-020 Stage 1 SHALL register: inv = infa & infb & (signa ^ signb ^ is_sub); inf = infa | infb; sign of the larger operand (b sign XOR is_sub); op_sub = signa ^ signb ^ is_sub; larger exponent; fractions and shift amount, all forced to 0 when inf.
REQ-021 The shift amount SHALL be |exp_a - exp_b|, saturated to 2^SHW-1.
REQ-022 Stage 2 SHALL right-shift {smaller_fract, 2'b00} and set sticky = OR of the bits shifted out (0 for shift ≤ 2).
REQ-023 Stage 2 SHALL form {0,larger,000} ± {0,shifted,sticky} in two's complement, keeping the top FRACTW+3 bits; sub_0 = a_eq_b & op_sub.
REQ-024 Stage 3 SHALL compute nlz = leading zeros below the carry bit (0 if carry set or result zero).
REQ-025 Stage 3 SHALL set (shl, exp_shl) = (0, exp) if nlz = 0 or exp = 1.
REQ-026 Otherwise stage 3 SHALL set (nlz, exp-nlz) if exp > nlz; (nlz-1, 1) if exp = nlz; else (exp-1, 1).
REQ-027 add_fract_o SHALL equal {stage-2 sum, stage-2 sticky}; add_exp_sh0_o SHALL equal the larger exponent.
REQ-028 Valid SHALL propagate start_i → v1 → v2 → add_rdy_o on adv_i. flush_i SHALL clear all valid bits next edge and override adv_i. Data registers SHALL not be flushed.
REQ-029 busy_o SHALL equal v1 | v2 | add_rdy_o.
REQ-030 With adv_i=0 all outputs SHALL hold, including add_rdy_o.

Reset
REQ-031 rst SHALL asynchronously clear v1, v2, add_rdy_o and busy_o. Data outputs are don't-care until the first valid result; reset mid-operation discards in-flight results.

Verification (FRACTW=24, EXPW=10, adv_i=1)
REQ-032 1.0+1.0 (exp 127, fract 0x800000 both) → after 3 cycles add_rdy_o=1, add_fract_o=0x8000000, add_shl_o=0, add_exp_sh0_o=127.
REQ-033 1.0-1.0 → add_sub_0_o=1, add_fract_o=0, add_shl_o=0, add_exp_shl_o=127.
REQ-034 a=(127,0x800000) + b=(87,0x800001): shift saturates at 31 → add_fract_o=0x4000001 (sticky=1).
REQ-035 +inf plus -inf → add_inv_o=1, add_inf_o=1, add_fract_o=0.
REQ-036 Stream start_i on 3 cycles, then adv_i=0 for 2 cycles → outputs frozen; flush_i next cycle → add_rdy_o=0 and busy_o=0 next edge.
REQ-037 rst asserted mid-stream, between clock edges → add_rdy_o and busy_o drop immediately.

Source files
------------

// File: rtl/pu_or1k_pfpu_addsub_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pu_or1k_pfpu_addsub_gen: 3-stage FP add/sub core (align, add, norm-prep)    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pu_or1k_pfpu_addsub_gen #(
  parameter int FRACTW = 24,
  parameter int EXPW   = 10,
  parameter int SHW    = $clog2(FRACTW + 3)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              adv_i,
  input  logic              start_i,
  input  logic              is_sub_i,
  input  logic              signa_i,
  input  logic              signb_i,
  input  logic [EXPW-1:0]   exp_a_i,
  input  logic [EXPW-1:0]   exp_b_i,
  input  logic [FRACTW-1:0] fract_a_i,
  input  logic [FRACTW-1:0] fract_b_i,
  input  logic              infa_i,
  input  logic              infb_i,
  input  logic              snan_i,
  input  logic              qnan_i,
  input  logic              anan_sign_i,
  output logic              add_rdy_o,
  output logic              add_sign_o,
  output logic              add_sub_0_o,
  output logic              add_inv_o,
  output logic              add_inf_o,
  output logic              add_snan_o,
  output logic              add_qnan_o,
  output logic              add_anan_sign_o,
  output logic [SHW-1:0]    add_shl_o,
  output logic [EXPW-1:0]   add_exp_shl_o,
  output logic [EXPW-1:0]   add_exp_sh0_o,
  output logic [FRACTW+3:0] add_fract_o,
  output logic              busy_o
);

  localparam int EXTW = FRACTW + 2;
  localparam int SUMW = FRACTW + 3;

  function automatic logic [SHW-1:0] lead_zeros(input logic [SUMW-1:0] v);
    int n;
    n = SUMW;
    for (int i = 0; i < SUMW; i++) begin
      if (v[i]) n = SUMW - 1 - i;
    end
    return SHW'(n);
  endfunction

  // valid chain
  logic v1, v2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      add_rdy_o <= 1'b0;
    end else if (flush_i) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      add_rdy_o <= 1'b0;
    end else if (adv_i) begin
      v1        <= start_i;
      v2        <= v1;
      add_rdy_o <= v2;
    end
  end

  assign busy_o = v1 | v2 | add_rdy_o;

  // stage 1: operand ordering and alignment distance
  logic              a_gt_b, a_eq_b, op_sub, inf_any;
  logic [EXPW-1:0]   exp_diff;
  logic [SHW-1:0]    shr_sat;

  always_comb begin
    a_gt_b   = {exp_a_i, fract_a_i} >  {exp_b_i, fract_b_i};
    a_eq_b   = {exp_a_i, fract_a_i} == {exp_b_i, fract_b_i};
    op_sub   = signa_i ^ signb_i ^ is_sub_i;
    inf_any  = infa_i | infb_i;
    exp_diff = a_gt_b ? (exp_a_i - exp_b_i) : (exp_b_i - exp_a_i);
    shr_sat  = (|exp_diff[EXPW-1:SHW]) ? '1 : exp_diff[SHW-1:0];
  end

  logic              s1_inv, s1_inf, s1_sign, s1_op_sub, s1_eq;
  logic              s1_snan, s1_qnan, s1_anan_sign;
  logic [EXPW-1:0]   s1_exp;
  logic [FRACTW-1:0] s1_fract_l, s1_fract_s;
  logic [SHW-1:0]    s1_shr;

  always_ff @(posedge clk) begin
    if (adv_i) begin
      s1_inv       <= infa_i & infb_i & op_sub;
      s1_inf       <= inf_any;
      s1_sign      <= a_gt_b ? signa_i : (signb_i ^ is_sub_i);
      s1_op_sub    <= op_sub;
      s1_eq        <= a_eq_b;
      s1_snan      <= snan_i;
      s1_qnan      <= qnan_i;
      s1_anan_sign <= anan_sign_i;
      s1_exp       <= a_gt_b ? exp_a_i : exp_b_i;
      s1_fract_l   <= inf_any ? '0 : (a_gt_b ? fract_a_i : fract_b_i);
      s1_fract_s   <= inf_any ? '0 : (a_gt_b ? fract_b_i : fract_a_i);
      s1_shr       <= inf_any ? '0 : shr_sat;
    end
  end

  // stage 2: right shift of the smaller operand with sticky collection, then add/sub
  logic [EXTW-1:0]   ext, shifted, out_mask;
  logic              sticky;
  logic [SUMW:0]     op_l, op_s, sum;

  always_comb begin
    ext      = {s1_fract_s, 2'b00};
    shifted  = ext >> s1_shr;
    out_mask = ~({EXTW{1'b1}} << s1_shr);
    sticky   = |(ext & out_mask);
    op_l     = {1'b0, s1_fract_l, 3'b000};
    op_s     = {1'b0, shifted, sticky};
    sum      = s1_op_sub ? (op_l - op_s) : (op_l + op_s);
  end

  logic              s2_sticky, s2_sub_0, s2_sign, s2_inv, s2_inf;
  logic              s2_snan, s2_qnan, s2_anan_sign;
  logic [SUMW-1:0]   s2_sum;
  logic [EXPW-1:0]   s2_exp;

  always_ff @(posedge clk) begin
    if (adv_i) begin
      s2_sum       <= sum[SUMW:1];
      s2_sticky    <= sticky;
      s2_sub_0     <= s1_eq & s1_op_sub;
      s2_sign      <= s1_sign;
      s2_inv       <= s1_inv;
      s2_inf       <= s1_inf;
      s2_snan      <= s1_snan;
      s2_qnan      <= s1_qnan;
      s2_anan_sign <= s1_anan_sign;
      s2_exp       <= s1_exp;
    end
  end

  // stage 3: left-normalise amount, clamped so the exponent never drops below 1
  logic [SUMW-1:0]   below;
  logic              carry;
  logic [SHW-1:0]    nlz, shl;
  logic [EXPW-1:0]   nlz_e, exp_shl;

  always_comb begin
    below = {s2_sum[SUMW-2:0], s2_sticky};
    carry = s2_sum[SUMW-1];
    nlz   = (carry || (below == '0)) ? '0 : lead_zeros(below);
    nlz_e = EXPW'(nlz);
    if ((nlz == '0) || (s2_exp == EXPW'(1))) begin
      shl     = '0;
      exp_shl = s2_exp;
    end else if (s2_exp > nlz_e) begin
      shl     = nlz;
      exp_shl = s2_exp - nlz_e;
    end else if (s2_exp == nlz_e) begin
      shl     = nlz - SHW'(1);
      exp_shl = EXPW'(1);
    end else begin
      shl     = SHW'(s2_exp - EXPW'(1));
      exp_shl = EXPW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (adv_i) begin
      add_sign_o      <= s2_sign;
      add_sub_0_o     <= s2_sub_0;
      add_inv_o       <= s2_inv;
      add_inf_o       <= s2_inf;
      add_snan_o      <= s2_snan;
      add_qnan_o      <= s2_qnan;
      add_anan_sign_o <= s2_anan_sign;
      add_shl_o       <= shl;
      add_exp_shl_o   <= exp_shl;
      add_exp_sh0_o   <= s2_exp;
      add_fract_o     <= {s2_sum, s2_sticky};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pu_or1k_pfpu_addsub_gen.sv
`default_nettype none
// Bench for pu_or1k_pfpu_addsub_gen: directed corner cases plus random streams
// checked against an integer-arithmetic reference with a 3-deep result pipe.
module tb_pu_or1k_pfpu_addsub_gen;

  typedef struct packed {
    logic        sign;
    logic        sub0;
    logic        inv;
    logic        inf;
    logic        snan;
    logic        qnan;
    logic        anan;
    logic [4:0]  shl;
    logic [9:0]  exp_shl;
    logic [9:0]  exp_sh0;
    logic [27:0] fract;
  } res_t;

  logic        clk, rst, flush, adv, start, is_sub, signa, signb;
  logic [9:0]  exp_a, exp_b;
  logic [23:0] fract_a, fract_b;
  logic        infa, infb, snan, qnan, anan_sign;
  logic        add_rdy_o, add_sign_o, add_sub_0_o, add_inv_o, add_inf_o;
  logic        add_snan_o, add_qnan_o, add_anan_sign_o, busy_o;
  logic [4:0]  add_shl_o;
  logic [9:0]  add_exp_shl_o, add_exp_sh0_o;
  logic [27:0] add_fract_o;
  res_t        got;

  int   vectors = 0;
  int   miscompares = 0;
  res_t pq [3];
  logic vq [3];

  pu_or1k_pfpu_addsub_gen dut (
    .clk(clk), .rst(rst), .flush_i(flush), .adv_i(adv), .start_i(start),
    .is_sub_i(is_sub), .signa_i(signa), .signb_i(signb),
    .exp_a_i(exp_a), .exp_b_i(exp_b), .fract_a_i(fract_a), .fract_b_i(fract_b),
    .infa_i(infa), .infb_i(infb), .snan_i(snan), .qnan_i(qnan), .anan_sign_i(anan_sign),
    .add_rdy_o(add_rdy_o), .add_sign_o(add_sign_o), .add_sub_0_o(add_sub_0_o),
    .add_inv_o(add_inv_o), .add_inf_o(add_inf_o), .add_snan_o(add_snan_o),
    .add_qnan_o(add_qnan_o), .add_anan_sign_o(add_anan_sign_o),
    .add_shl_o(add_shl_o), .add_exp_shl_o(add_exp_shl_o), .add_exp_sh0_o(add_exp_sh0_o),
    .add_fract_o(add_fract_o), .busy_o(busy_o)
  );

  assign got = {add_sign_o, add_sub_0_o, add_inv_o, add_inf_o, add_snan_o, add_qnan_o,
                add_anan_sign_o, add_shl_o, add_exp_shl_o, add_exp_sh0_o, add_fract_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: magnitudes as integers, alignment by plain division-style shifts.
  function automatic res_t model(input logic sa, sb, sub, input logic [9:0] ea, eb,
                                 input logic [23:0] fa, fb, input logic ia, ib, sn, qn, an);
    res_t   r;
    longint ma, mb, fl, fs, ext, shifted, a_op, b_op, sm, fr;
    int     el, diff, shr, nlz, shl, es;
    logic   agtb, aeqb, opsub, stk;
    ma    = longint'({ea, fa});
    mb    = longint'({eb, fb});
    agtb  = ma > mb;
    aeqb  = ma == mb;
    opsub = sa ^ sb ^ sub;
    el    = agtb ? int'(ea) : int'(eb);
    diff  = agtb ? int'(ea) - int'(eb) : int'(eb) - int'(ea);
    shr   = (diff > 31) ? 31 : diff;
    fl    = agtb ? longint'(fa) : longint'(fb);
    fs    = agtb ? longint'(fb) : longint'(fa);
    if (ia || ib) begin
      fl = 0; fs = 0; shr = 0;
    end
    ext     = fs * 4;
    shifted = ext >> shr;
    stk     = (ext & ((64'sd1 <<< shr) - 64'sd1)) != 0;
    a_op    = fl * 8;
    b_op    = shifted * 2 + longint'(stk);
    sm      = (opsub ? a_op - b_op : a_op + b_op) & 64'h0FFF_FFFF;
    fr      = (sm & ~64'sd1) | longint'(stk);
    nlz     = 0;
    if (((fr >> 27) & 1) == 0 && fr != 0) begin
      for (int i = 26; i >= 0; i--) begin
        if (((fr >> i) & 1) != 0) begin
          nlz = 26 - i;
          break;
        end
      end
    end
    if (nlz == 0 || el == 1) begin shl = 0;       es = el;       end
    else if (el > nlz)       begin shl = nlz;     es = el - nlz; end
    else if (el == nlz)      begin shl = nlz - 1; es = 1;        end
    else                     begin shl = el - 1;  es = 1;        end
    r.sign    = agtb ? sa : (sb ^ sub);
    r.sub0    = aeqb & opsub;
    r.inv     = ia & ib & opsub;
    r.inf     = ia | ib;
    r.snan    = sn;
    r.qnan    = qn;
    r.anan    = an;
    r.shl     = 5'(shl);
    r.exp_shl = 10'(es);
    r.exp_sh0 = 10'(el);
    r.fract   = 28'(fr);
    return r;
  endfunction

  // One clock edge; the expected pipe advances exactly as the spec describes.
  task automatic tick();
    res_t e;
    e = model(signa, signb, is_sub, exp_a, exp_b, fract_a, fract_b, infa, infb, snan, qnan, anan_sign);
    @(posedge clk);
    #1;
    if (adv) begin
      pq[2] = pq[1]; pq[1] = pq[0]; pq[0] = e;
    end
    if (flush) begin
      vq[0] = 1'b0; vq[1] = 1'b0; vq[2] = 1'b0;
    end else if (adv) begin
      vq[2] = vq[1]; vq[1] = vq[0]; vq[0] = start;
    end
  endtask

  task automatic set_op(input logic sa, sb, sub, input logic [9:0] ea, eb,
                        input logic [23:0] fa, fb, input logic ia, ib);
    signa = sa; signb = sb; is_sub = sub; exp_a = ea; exp_b = eb;
    fract_a = fa; fract_b = fb; infa = ia; infb = ib;
    snan = 1'b0; qnan = 1'b0; anan_sign = 1'b0;
  endtask

  task automatic rand_op();
    int mode;
    mode    = $urandom_range(0, 3);
    exp_a   = 10'($urandom_range(1, 300));
    fract_a = 24'($urandom) | (($urandom_range(0, 7) != 0) ? 24'h800000 : 24'h0);
    fract_b = 24'($urandom) | (($urandom_range(0, 7) != 0) ? 24'h800000 : 24'h0);
    case (mode)
      0: exp_b = 10'($urandom_range(1, 300));
      1: begin exp_b = exp_a; fract_b = fract_a ^ 24'($urandom_range(0, 255)); end
      2: exp_b = exp_a + 10'($urandom_range(0, 2));
      default: begin exp_a = 10'($urandom_range(1, 5)); exp_b = 10'($urandom_range(1, 5)); end
    endcase
    signa     = 1'($urandom);
    signb     = 1'($urandom);
    is_sub    = 1'($urandom);
    infa      = ($urandom_range(0, 15) == 0);
    infb      = ($urandom_range(0, 15) == 0);
    snan      = 1'($urandom);
    qnan      = 1'($urandom);
    anan_sign = 1'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; adv = 1'b1; start = 1'b0;
    set_op(0, 0, 0, 10'd1, 10'd1, 24'h0, 24'h0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (add_rdy_o !== 1'b0 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state rdy=%b busy=%b expected 0 0", add_rdy_o, busy_o);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin vq[i] = 1'b0; end
    tick();
  endtask

  task automatic test_directed();
    // 1.0 + 1.0
    set_op(0, 0, 0, 10'd127, 10'd127, 24'h800000, 24'h800000, 0, 0);
    start = 1'b1; tick(); start = 1'b0; tick(); tick();
    vectors++;
    if (add_rdy_o !== 1'b1 || add_fract_o !== 28'h8000000 || add_shl_o !== 5'd0 || add_exp_sh0_o !== 10'd127) begin
      miscompares++;
      $display("FAIL one_plus_one rdy=%b fract=%h shl=%0d exp0=%0d expected 1 8000000 0 127",
               add_rdy_o, add_fract_o, add_shl_o, add_exp_sh0_o);
    end
    // 1.0 - 1.0
    set_op(0, 0, 1, 10'd127, 10'd127, 24'h800000, 24'h800000, 0, 0);
    start = 1'b1; tick(); start = 1'b0; tick(); tick();
    vectors++;
    if (add_rdy_o !== 1'b1 || add_sub_0_o !== 1'b1 || add_fract_o !== 28'h0 || add_shl_o !== 5'd0 || add_exp_shl_o !== 10'd127) begin
      miscompares++;
      $display("FAIL one_minus_one rdy=%b sub0=%b fract=%h shl=%0d exps=%0d expected 1 1 0 0 127",
               add_rdy_o, add_sub_0_o, add_fract_o, add_shl_o, add_exp_shl_o);
    end
    // saturating alignment shift, everything lands in sticky
    set_op(0, 0, 0, 10'd127, 10'd87, 24'h800000, 24'h800001, 0, 0);
    start = 1'b1; tick(); start = 1'b0; tick(); tick();
    vectors++;
    if (add_rdy_o !== 1'b1 || add_fract_o !== 28'h4000001) begin
      miscompares++;
      $display("FAIL shift_saturate rdy=%b fract=%h expected 1 4000001", add_rdy_o, add_fract_o);
    end
    // +inf + -inf
    set_op(0, 1, 0, 10'd255, 10'd255, 24'h800000, 24'h800000, 1, 1);
    start = 1'b1; tick(); start = 1'b0; tick(); tick();
    vectors++;
    if (add_rdy_o !== 1'b1 || add_inv_o !== 1'b1 || add_inf_o !== 1'b1 || add_fract_o !== 28'h0) begin
      miscompares++;
      $display("FAIL inf_minus_inf rdy=%b inv=%b inf=%b fract=%h expected 1 1 1 0",
               add_rdy_o, add_inv_o, add_inf_o, add_fract_o);
    end
    vectors++;
    if (got !== pq[2]) begin
      miscompares++;
      $display("FAIL inf_model got=%h expected %h", got, pq[2]);
    end
    tick(); tick();
  endtask

  task automatic test_random_stream(input int n, input bit stall);
    for (int k = 0; k < n; k++) begin
      rand_op();
      start = ($urandom_range(0, 3) != 0);
      adv   = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      flush = stall ? ($urandom_range(0, 19) == 0) : 1'b0;
      tick();
      vectors++;
      if (add_rdy_o !== vq[2] || busy_o !== (vq[0] | vq[1] | vq[2])) begin
        miscompares++;
        $display("FAIL stream_ctrl k=%0d rdy=%b busy=%b expected %b %b",
                 k, add_rdy_o, busy_o, vq[2], vq[0] | vq[1] | vq[2]);
      end
      if (vq[2]) begin
        vectors++;
        if (got !== pq[2]) begin
          miscompares++;
          $display("FAIL stream_data k=%0d got=%h expected %h", k, got, pq[2]);
        end
      end
    end
    adv = 1'b1; flush = 1'b0; start = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_stall_flush();
    res_t snap;
    adv = 1'b1; flush = 1'b0;
    for (int k = 0; k < 3; k++) begin rand_op(); start = 1'b1; tick(); end
    start = 1'b0;
    snap = got;
    vectors++;
    if (add_rdy_o !== 1'b1 || got !== pq[2]) begin
      miscompares++;
      $display("FAIL stall_first rdy=%b got=%h expected 1 %h", add_rdy_o, got, pq[2]);
    end
    adv = 1'b0;
    rand_op();
    tick(); tick();
    vectors++;
    if (add_rdy_o !== 1'b1 || busy_o !== 1'b1 || got !== snap) begin
      miscompares++;
      $display("FAIL stall_hold rdy=%b busy=%b got=%h expected 1 1 %h", add_rdy_o, busy_o, got, snap);
    end
    flush = 1'b1;
    tick();
    vectors++;
    if (add_rdy_o !== 1'b0 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_clear rdy=%b busy=%b expected 0 0", add_rdy_o, busy_o);
    end
    flush = 1'b0; adv = 1'b1;
    tick();
  endtask

  task automatic test_async_reset();
    adv = 1'b1; flush = 1'b0;
    for (int k = 0; k < 3; k++) begin rand_op(); start = 1'b1; tick(); end
    start = 1'b0;
    #3;
    vectors++;
    if (add_rdy_o !== 1'b1 || busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset rdy=%b busy=%b expected 1 1", add_rdy_o, busy_o);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (add_rdy_o !== 1'b0 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset rdy=%b busy=%b expected 0 0", add_rdy_o, busy_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin vq[i] = 1'b0; end
    tick();
    vectors++;
    if (add_rdy_o !== 1'b0 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset rdy=%b busy=%b expected 0 0", add_rdy_o, busy_o);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin vq[i] = 1'b0; pq[i] = '0; end
    test_reset();
    test_directed();
    test_random_stream(400, 1'b0);
    test_random_stream(400, 1'b1);
    test_stall_flush();
    test_async_reset();
    test_random_stream(100, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
